// File: rtl/rle_pixel_scheduler_if.sv
// Run-entry stream between the RLE decode/fetch path and rle_pixel_scheduler.
// Upstream drives the master modport; the scheduler takes the slave modport.
interface rle_pixel_scheduler_if #(
    parameter int COLOUR_BITS = 6,
    parameter int LEN_BITS    = 10
) ();
    logic                   run_valid;
    logic                   run_ready;
    logic [LEN_BITS-1:0]    run_len;
    logic [COLOUR_BITS-1:0] run_colour;

    modport master (
        output run_valid,
        output run_len,
        output run_colour,
        input  run_ready
    );

    modport slave (
        input  run_valid,
        input  run_len,
        input  run_colour,
        output run_ready
    );
endinterface

// File: rtl/rle_pixel_scheduler.sv
// Plays run-length entries onto the raster, one pixel per clk, with one current and one prefetched run.
// Optional RLE_FRAME_RESYNC_EN: next_frame drops both slots so a misaligned stream recovers within one frame.
module rle_pixel_scheduler #(
    parameter int COLOUR_BITS = 6,
    parameter int LEN_BITS    = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   blank,
    input  logic                   next_frame,
    rle_pixel_scheduler_if.slave   run,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   underflow
);

    typedef enum logic {
        WAIT_FRAME,
        ACTIVE
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [LEN_BITS-1:0]    len;
        logic [COLOUR_BITS-1:0] colour;
    } slot_t;

    state_t                 state_q, state_d;
    slot_t                  cur_q, cur_d;
    slot_t                  nxt_q, nxt_d;
    slot_t                  in_slot, src_a, src_b;
    logic                   ready_q;
    logic                   hs;
    logic                   active_px;
    logic                   take;
    logic [COLOUR_BITS-1:0] colour_d;
    logic                   underflow_d;

    // ready is a flop copy of !nxt_valid, so upstream never sees a path from run_valid or blank.
    assign run.run_ready = ready_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        hs          = run.run_valid && ready_q;
        in_slot     = '{valid: hs && (run.run_len != '0), len: run.run_len, colour: run.run_colour};
        active_px   = (state_q == ACTIVE) && !blank;
        state_d     = state_q;

        // Candidate runs in play order; at most two can be valid because a
        // handshake only happens while the next slot is empty.
        src_a = cur_q.valid ? cur_q : (nxt_q.valid ? nxt_q : in_slot);
        src_b = cur_q.valid ? (nxt_q.valid ? nxt_q : in_slot) : '0;

        take        = active_px && src_a.valid;
        colour_d    = take ? src_a.colour : '0;
        underflow_d = (active_px && !src_a.valid) || (underflow && !next_frame);

        cur_d = src_a;
        nxt_d = src_b;
        if (take) begin
            if (src_a.len == LEN_BITS'(1)) begin
                // Run expires this pixel; the follower moves up with no bubble.
                cur_d = src_b;
                nxt_d = '0;
            end else begin
                cur_d.len = src_a.len - LEN_BITS'(1);
            end
        end

`ifdef RLE_FRAME_RESYNC_EN
        if (next_frame) begin
            cur_d = '0;
            nxt_d = in_slot;
        end
`endif

        if (next_frame) begin
            state_d = ACTIVE;
        end
    end

    // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= WAIT_FRAME;
            cur_q     <= '0;
            nxt_q     <= '0;
            ready_q   <= 1'b0;
            colour    <= '0;
            underflow <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            ready_q   <= !nxt_d.valid;
            colour    <= colour_d;
            underflow <= underflow_d;
        end
    end

endmodule

// File: tb/tb_rle_pixel_scheduler.sv
// Directed bench for rle_pixel_scheduler: prefetch, row span, bypass, underflow, frame resync, reset mid-run.
module tb_rle_pixel_scheduler;

    logic       clk;
    logic       reset_n;
    logic       blank;
    logic       next_frame;
    logic [5:0] colour;
    logic       underflow;

    int tests_run = 0;
    int tests_failed = 0;

    rle_pixel_scheduler_if #(.COLOUR_BITS(6), .LEN_BITS(10)) run_bus ();

    rle_pixel_scheduler #(.COLOUR_BITS(6), .LEN_BITS(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .blank      (blank),
        .next_frame (next_frame),
        .run        (run_bus),
        .colour     (colour),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the posedge take them, return at the next negedge.
    task automatic cyc(input bit b, input bit nf, input bit v, input int len, input int col);
        blank              = b;
        next_frame         = nf;
        run_bus.run_valid  = v;
        run_bus.run_len    = 10'(len);
        run_bus.run_colour = 6'(col);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] pf_exp [5];
        logic       rs_blank [6];
        logic [5:0] rs_exp [6];
        pf_exp   = '{6'h30, 6'h30, 6'h30, 6'h0C, 6'h0C};
        rs_blank = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rs_exp   = '{6'h03, 6'h03, 6'h00, 6'h00, 6'h03, 6'h03};

        reset_n            = 1'b0;
        blank              = 1'b1;
        next_frame         = 1'b0;
        run_bus.run_valid  = 1'b0;
        run_bus.run_len    = '0;
        run_bus.run_colour = '0;
        repeat (2) @(negedge clk);
        check("rst_colour", 32'(colour), 32'h0);
        check("rst_ready", 32'(run_bus.run_ready), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        reset_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        check("ready_after_rst", 32'(run_bus.run_ready), 32'h1);

        // Prefetch two runs before the first frame, then play them back to back.
        cyc(1, 0, 1, 3, 'h30);
        check("pf_ready_one", 32'(run_bus.run_ready), 32'h1);
        cyc(0, 0, 1, 2, 'h0C);
        check("pf_ready_full", 32'(run_bus.run_ready), 32'h0);
        check("pf_wait_colour", 32'(colour), 32'h0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            check($sformatf("pf_px%0d", i), 32'(colour), 32'(pf_exp[i]));
            if (i == 2) check("pf_ready_refill", 32'(run_bus.run_ready), 32'h1);
        end
        check("pf_underflow", 32'(underflow), 32'h0);

        // Run spans a blanking gap; only visible pixels consume it.
        cyc(1, 0, 1, 4, 'h03);
        check("rs_load_colour", 32'(colour), 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(rs_blank[i], 0, 0, 0, 0);
            check($sformatf("rs_px%0d", i), 32'(colour), 32'(rs_exp[i]));
        end
        check("rs_underflow", 32'(underflow), 32'h0);

        // Bypass on expiry with an empty next slot, then a zero-length entry.
        cyc(1, 0, 1, 2, 'h2A);
        cyc(0, 0, 0, 0, 0);
        check("bp_px0", 32'(colour), 32'h2A);
        cyc(0, 0, 1, 1, 'h15);
        check("bp_px1", 32'(colour), 32'h2A);
        cyc(0, 0, 0, 0, 0);
        check("bp_px2", 32'(colour), 32'h15);
        check("bp_underflow", 32'(underflow), 32'h0);
        cyc(1, 0, 1, 0, 'h3F);
        check("zero_ready", 32'(run_bus.run_ready), 32'h1);
        check("zero_colour", 32'(colour), 32'h0);
        cyc(1, 0, 1, 1, 'h21);
        cyc(0, 0, 0, 0, 0);
        check("zero_next_px", 32'(colour), 32'h21);
        check("zero_underflow", 32'(underflow), 32'h0);

        // Starvation: sticky underflow, cleared by next_frame unless it recurs there.
        cyc(1, 0, 1, 1, 'h11);
        cyc(0, 0, 0, 0, 0);
        check("uf_px0", 32'(colour), 32'h11);
        check("uf_flag0", 32'(underflow), 32'h0);
        cyc(0, 0, 0, 0, 0);
        check("uf_px1", 32'(colour), 32'h0);
        check("uf_flag1", 32'(underflow), 32'h1);
        cyc(0, 0, 0, 0, 0);
        check("uf_px2", 32'(colour), 32'h0);
        cyc(1, 0, 0, 0, 0);
        check("uf_sticky", 32'(underflow), 32'h1);
        cyc(1, 1, 0, 0, 0);
        check("uf_clear", 32'(underflow), 32'h0);
        cyc(0, 1, 0, 0, 0);
        check("uf_at_frame", 32'(underflow), 32'h1);
        cyc(1, 0, 0, 0, 0);
        check("uf_at_frame_hold", 32'(underflow), 32'h1);
        cyc(1, 1, 0, 0, 0);
        check("uf_clear2", 32'(underflow), 32'h0);

        // Both slots full across a frame boundary.
        cyc(1, 0, 1, 7, 'h07);
        cyc(1, 0, 1, 2, 'h1A);
        check("fr_ready_full", 32'(run_bus.run_ready), 32'h0);
        cyc(1, 1, 0, 0, 0);
`ifdef RLE_FRAME_RESYNC_EN
        check("fr_ready_dropped", 32'(run_bus.run_ready), 32'h1);
        cyc(0, 0, 0, 0, 0);
        check("fr_px0", 32'(colour), 32'h0);
        check("fr_underflow", 32'(underflow), 32'h1);
`else
        check("fr_ready_kept", 32'(run_bus.run_ready), 32'h0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 0);
            check($sformatf("fr_px%0d", i), 32'(colour), 32'h07);
        end
        for (int i = 7; i < 9; i++) begin
            cyc(0, 0, 0, 0, 0);
            check($sformatf("fr_px%0d", i), 32'(colour), 32'h1A);
        end
        check("fr_underflow", 32'(underflow), 32'h0);
`endif

        // Reset mid-run with five pixels left in cur.
        cyc(1, 0, 1, 8, 'h2C);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            check($sformatf("mr_px%0d", i), 32'(colour), 32'h2C);
        end
        reset_n = 1'b0;
        #1;
        check("mr_rst_colour", 32'(colour), 32'h0);
        check("mr_rst_ready", 32'(run_bus.run_ready), 32'h0);
        check("mr_rst_underflow", 32'(underflow), 32'h0);
        @(negedge clk);
        check("mr_rst_ready_held", 32'(run_bus.run_ready), 32'h0);
        reset_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("mr_ready_after", 32'(run_bus.run_ready), 32'h1);
        check("mr_wait_colour", 32'(colour), 32'h0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("mr_cur_dropped", 32'(colour), 32'h0);
        check("mr_underflow", 32'(underflow), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
